wash_phase_timer: RTL
=====================

Name: wash_phase_timer

Overview:
- Timing controller that sequences the wash and spin phases of the washing-machine control FSM.
- Watches the FSM's phase indicators (motor running in wash, spin phase active), counts programmable durations in prescaled seconds, and returns cycle_timeout / spin_timeout to the FSM.
- Timeouts are level handshakes: each is held until the FSM acknowledges by leaving the phase.
- Supports pause (door/user) and abort, and exposes remaining time for display.

Parameters:
- TICK_DIV, 50000000, clk cycles per time unit (1 s at 50 MHz); must be >= 2.
- CNT_W, 8, width of duration inputs and the remaining-time counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wash_active  in  1  high while the FSM is in the wash cycle (driven from motor_on).
- spin_active  in  1  high while the FSM is in the spin state.
- pause  in  1  high freezes all counting.
- wash_time  in  CNT_W  wash duration in ticks; sampled on wash phase entry.
- spin_time  in  CNT_W  spin duration in ticks; sampled on spin phase entry.
- cycle_timeout  out  1  wash duration expired; level, held until wash_active falls.
- spin_timeout  out  1  spin duration expired; level, held until spin_active falls.
- remaining  out  CNT_W  ticks left in the current phase; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- tick  out  1  one-cycle pulse on each prescaler wrap.

Behaviour:
- All outputs are registered. During reset: state=IDLE, prescaler=0, remaining=0, cycle_timeout=0, spin_timeout=0, busy=0, tick=0.
- States: IDLE, WASH, WASH_TO, SPIN, SPIN_TO (3-bit encoding). Unused encodings go to IDLE with all outputs cleared.
- IDLE:
  - wash_active=1: load remaining=wash_time, prescaler=0, go to WASH.
  - Otherwise spin_active=1: load remaining=spin_time, prescaler=0, go to SPIN.
  - wash_active has priority when both are high.
- WASH and SPIN:
  - Active input low: abort. Go to IDLE, remaining=0, no timeout asserted. Abort takes priority over pause and over a simultaneous tick.
  - pause=1: prescaler, remaining and tick are frozen (tick=0).
  - Otherwise the prescaler increments each cycle. When prescaler==TICK_DIV-1: prescaler=0, tick=1 for one cycle, remaining decrements by 1.
  - When remaining==1 and a tick occurs: remaining becomes 0 and the state moves to WASH_TO or SPIN_TO. The matching timeout goes high on that same edge.
  - If the loaded duration is 0: go to the *_TO state on the next edge (one-cycle latency).
- Latency: with duration N>0 and no pause, the timeout rises exactly N*TICK_DIV clk edges after the entry edge. Each paused cycle adds one edge.
- WASH_TO / SPIN_TO:
  - The timeout is held high and remaining=0. pause has no effect.
  - When the active input falls: timeout drops on the next edge and the state returns to IDLE.
- Back-to-back phases: if wash_active falls and spin_active is already high in the same cycle, pass through IDLE for one cycle, then enter SPIN. The IDLE cycle is mandatory.
- wash_time and spin_time changes mid-phase are ignored.
- Reset asserted mid-phase: immediate return to reset values with no timeout pulse. Counting restarts only on the next active input after reset deasserts.
- remaining never underflows. The decrement is gated by remaining!=0.

Test Plan (TICK_DIV=4 in all scenarios):
- Reset low for 3 cycles, then high with wash_active=0 and spin_active=0 -> all outputs 0, busy=0, no tick for 50 cycles.
- wash_time=3, wash_active rises and stays high -> busy=1, remaining 3,2,1,0 with ticks 4 edges apart; cycle_timeout rises 12 edges after entry and stays high. wash_active drops -> cycle_timeout=0 one edge later, state IDLE.
- spin_time=2, spin_active high, pause high for 5 cycles mid-count -> spin_timeout rises at 8+5=13 edges after entry; remaining held constant during pause.
- wash_time=5, wash_active dropped after 6 cycles (remaining=4) -> IDLE next edge, remaining=0, cycle_timeout never asserts.
- wash_time=0 -> cycle_timeout high one edge after entry. Then wash_active and spin_active swap in the same cycle -> one IDLE cycle, then SPIN loads spin_time.
- Async reset pulse while in SPIN with remaining=7 -> outputs clear without a clock edge. Re-raising spin_active reloads spin_time and counting restarts from prescaler 0.

Source files
------------

// File: rtl/wash_phase_timer_if.sv
// Phase-timer bus between the washer control FSM and its timing controller.
// Latency: none (signal bundle only).
// Backpressure: none; timeouts are level handshakes released by the FSM leaving the phase.
//
// Ports (members):
//   wash_active, spin_active, pause  : FSM phase indicators and freeze request
//   wash_time, spin_time             : phase durations in ticks, sampled on phase entry
//   cycle_timeout, spin_timeout      : level timeouts back to the FSM
//   remaining, busy, tick            : display / status outputs
interface wash_phase_timer_if #(
    parameter int CNT_W = 8
) ();
    logic             wash_active;
    logic             spin_active;
    logic             pause;
    logic [CNT_W-1:0] wash_time;
    logic [CNT_W-1:0] spin_time;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             tick;

    // FSM side: drives phase indicators and durations, observes timeouts/status.
    modport master (
        output wash_active, spin_active, pause, wash_time, spin_time,
        input  cycle_timeout, spin_timeout, remaining, busy, tick
    );

    // Timer side.
    modport slave (
        input  wash_active, spin_active, pause, wash_time, spin_time,
        output cycle_timeout, spin_timeout, remaining, busy, tick
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Wash/spin phase timer: counts programmable durations in prescaled ticks and raises level timeouts.
// Latency: timeout rises N*TICK_DIV edges after phase entry (+1 per paused cycle); 1 edge for N=0.
// Backpressure: pause freezes counting; timeouts held until the FSM drops the phase's active input.
//
// Ports:
//   clk_i     : system clock, rising edge
//   reset_ni  : asynchronous active-low reset
//   bus       : wash_phase_timer_if slave modport (phase inputs, durations, timeouts, status)
module wash_phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    wash_phase_timer_if.slave     bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WASH    = 3'd1;
    localparam logic [2:0] S_WASH_TO = 3'd2;
    localparam logic [2:0] S_SPIN    = 3'd3;
    localparam logic [2:0] S_SPIN_TO = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             cto_q, cto_d;
    logic             sto_q, sto_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;

    // Per-phase view so WASH and SPIN share one counting path.
    logic       phase_act;
    logic [2:0] phase_to;

    always_comb begin
        phase_act = (state_q == S_WASH) ? bus.wash_active : bus.spin_active;
        phase_to  = (state_q == S_WASH) ? S_WASH_TO : S_SPIN_TO;
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        tick_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                rem_d   = '0;
                // Wash wins if both phases are requested together.
                if (bus.wash_active) begin
                    state_d = S_WASH;
                    rem_d   = bus.wash_time;
                end else if (bus.spin_active) begin
                    state_d = S_SPIN;
                    rem_d   = bus.spin_time;
                end
            end

            S_WASH, S_SPIN: begin
                if (!phase_act) begin
                    // Abort beats pause and any tick due this cycle.
                    state_d = S_IDLE;
                    presc_d = '0;
                    rem_d   = '0;
                end else if (rem_q == '0) begin
                    // Zero-length phase expires on the edge after entry.
                    state_d = phase_to;
                    presc_d = '0;
                end else if (!bus.pause) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        rem_d   = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = phase_to;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end

            S_WASH_TO: begin
                presc_d = '0;
                rem_d   = '0;
                if (!bus.wash_active) begin
                    state_d = S_IDLE;
                end
            end

            S_SPIN_TO: begin
                presc_d = '0;
                rem_d   = '0;
                if (!bus.spin_active) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                rem_d   = '0;
            end
        endcase

        // Timeouts and busy follow the next state so they change on the same edge as it.
        cto_d  = (state_d == S_WASH_TO);
        sto_d  = (state_d == S_SPIN_TO);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            rem_q   <= '0;
            cto_q   <= 1'b0;
            sto_q   <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            cto_q   <= cto_d;
            sto_q   <= sto_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.cycle_timeout = cto_q;
    assign bus.spin_timeout  = sto_q;
    assign bus.remaining     = rem_q;
    assign bus.busy          = busy_q;
    assign bus.tick          = tick_q;

endmodule
